// File: rtl/fp_adder_pipe.sv
// fp_adder_pipe: three-stage floating-point add/subtract, RNE, flush-to-zero.
// Ports: a/b/op/in_vld/in_rdy operand side, z/z_ovf/z_inv/z_vld/z_rdy result side.
module fp_adder_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   op,
    input  logic                   in_vld,
    output logic                   in_rdy,
    output logic [EXP_W+MAN_W:0]   z,
    output logic                   z_ovf,
    output logic                   z_inv,
    output logic                   z_vld,
    input  logic                   z_rdy
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 4;
    localparam int EW = EXP_W + $clog2(N) + 2;
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             sign;
        logic             sub;
        logic             sp;
        logic             inv;
        logic [W-1:0]     spz;
        logic [EXP_W-1:0] exp;
        logic [N-1:0]     mx;
        logic [N-1:0]     my;
    } s1_t;

    typedef struct packed {
        logic          sign;
        logic          sp;
        logic          inv;
        logic [W-1:0]  spz;
        logic          zero;
        logic [EW-1:0] exp;
        logic [N-2:0]  man;
    } s2_t;

    logic v1, v2, v3;
    logic rdy2, rdy3;

    assign rdy3   = ~v3 | z_rdy;
    assign rdy2   = ~v2 | rdy3;
    assign in_rdy = ~v1 | rdy2;
    assign z_vld  = v3;

    // ---------------- stage 1: unpack, specials, align ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, ex, ey, d;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic             a_ge;
    logic [MAN_W:0]   mxs, mys;
    logic [2*N-1:0]   wide;
    s1_t              s1_d, s1_q;

    assign sa = a[W-1];
    assign sb = b[W-1] ^ op;
    assign ea = a[W-2:MAN_W];
    assign eb = b[W-2:MAN_W];
    assign ma = a[MAN_W-1:0];
    assign mb = b[MAN_W-1:0];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_nan  = (&ea) & (|ma);
    assign b_nan  = (&eb) & (|mb);
    assign a_inf  = (&ea) & ~(|ma);
    assign b_inf  = (&eb) & ~(|mb);

    assign a_ge = {ea, ma} >= {eb, mb};
    assign ex   = a_ge ? ea : eb;
    assign ey   = a_ge ? eb : ea;
    assign mxs  = a_ge ? {1'b1, ma} : {1'b1, mb};
    assign mys  = a_ge ? {1'b1, mb} : {1'b1, ma};
    assign d    = ex - ey;

    // Y sits in the upper half; everything falling into the lower half is sticky.
    assign wide = {mys, 3'b000, {N{1'b0}}} >> d;

    always_comb begin
        s1_d      = '0;
        s1_d.sign = a_ge ? sa : sb;
        s1_d.sub  = sa ^ sb;
        s1_d.exp  = ex;
        s1_d.mx   = {mxs, 3'b000};
        if (int'(d) >= N)
            s1_d.my = N'(1);
        else
            s1_d.my = {wide[2*N-1:N+1], wide[N] | (|wide[N-1:0])};

        if (a_nan | b_nan) begin
            s1_d.sp  = 1'b1;
            s1_d.spz = QNAN;
            s1_d.inv = 1'b1;
        end else if (a_inf & b_inf) begin
            s1_d.sp = 1'b1;
            if (sa != sb) begin
                s1_d.spz = QNAN;
                s1_d.inv = 1'b1;
            end else begin
                s1_d.spz = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end else if (a_inf) begin
            s1_d.sp  = 1'b1;
            s1_d.spz = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_d.sp  = 1'b1;
            s1_d.spz = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero & b_zero) begin
            s1_d.sp  = 1'b1;
            s1_d.spz = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            s1_d.sp  = 1'b1;
            s1_d.spz = {sb, b[W-2:0]};
        end else if (b_zero) begin
            s1_d.sp  = 1'b1;
            s1_d.spz = a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            v1 <= 1'b0;
        else if (in_rdy)
            v1 <= in_vld;
    end

    always_ff @(posedge clk) begin
        if (in_rdy && in_vld)
            s1_q <= s1_d;
    end

    // ---------------- stage 2: add and normalise ----------------
    logic [N:0]    sum;
    logic [EW-1:0] lz;
    logic          found;
    logic [N-1:0]  nm;
    logic [EW-1:0] ne;
    s2_t           s2_d, s2_q;

    assign sum = s1_q.sub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my})
                          : ({1'b0, s1_q.mx} + {1'b0, s1_q.my});

    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = EW'(N - 1 - i);
                found = 1'b1;
            end
        end
        nm = sum[N-1:0] << lz;
        ne = {{(EW-EXP_W){1'b0}}, s1_q.exp} - lz;
        if (sum[N]) begin
            nm = {sum[N:2], sum[1] | sum[0]};
            ne = {{(EW-EXP_W){1'b0}}, s1_q.exp} + EW'(1);
        end
    end

    // After normalisation the hidden bit is clear only for an exact zero.
    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.sp   = s1_q.sp;
        s2_d.inv  = s1_q.inv;
        s2_d.spz  = s1_q.spz;
        s2_d.zero = ~nm[N-1];
        s2_d.exp  = ne;
        s2_d.man  = nm[N-2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            v2 <= 1'b0;
        else if (rdy2)
            v2 <= v1;
    end

    always_ff @(posedge clk) begin
        if (rdy2 && v1)
            s2_q <= s2_d;
    end

    // ---------------- stage 3: round and pack ----------------
    logic          inc;
    logic [MAN_W:0] mr;
    logic [EW-1:0] re;
    logic [W-1:0]  r_z;
    logic          r_ovf, r_inv;

    assign inc = s2_q.man[2] & (s2_q.man[1] | s2_q.man[0] | s2_q.man[3]);
    assign mr  = {1'b0, s2_q.man[N-2:3]} + (MAN_W+1)'(inc);
    assign re  = s2_q.exp + EW'(mr[MAN_W]);

    always_comb begin
        r_z   = '0;
        r_ovf = 1'b0;
        r_inv = 1'b0;
        if (s2_q.sp) begin
            r_z   = s2_q.spz;
            r_inv = s2_q.inv;
        end else if (s2_q.zero) begin
            r_z = '0;
        end else if (re[EW-1] || re == '0) begin
            r_z = {s2_q.sign, {(W-1){1'b0}}};
        end else if (re >= EMAX) begin
            r_z   = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r_ovf = 1'b1;
        end else begin
            r_z = {s2_q.sign, re[EXP_W-1:0], mr[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3    <= 1'b0;
            z     <= '0;
            z_ovf <= 1'b0;
            z_inv <= 1'b0;
        end else if (rdy3) begin
            v3 <= v2;
            if (v2) begin
                z     <= r_z;
                z_ovf <= r_ovf;
                z_inv <= r_inv;
            end
        end
    end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// tb_fp_adder_pipe: directed checks of fp_adder_pipe (bf16 and fp16).
// Vectors pack {a, b, op, z, ovf, inv}.
module tb_fp_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] a, b, z;
    logic        op, in_vld, in_rdy, z_ovf, z_inv, z_vld, z_rdy;

    logic [15:0] h_a, h_b, h_z;
    logic        h_op, h_in_vld, h_in_rdy, h_z_ovf, h_z_inv, h_z_vld, h_z_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_adder_pipe #(.EXP_W(8), .MAN_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
        .in_vld(in_vld), .in_rdy(in_rdy), .z(z), .z_ovf(z_ovf),
        .z_inv(z_inv), .z_vld(z_vld), .z_rdy(z_rdy)
    );

    fp_adder_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(h_a), .b(h_b), .op(h_op),
        .in_vld(h_in_vld), .in_rdy(h_in_rdy), .z(h_z), .z_ovf(h_z_ovf),
        .z_inv(h_z_inv), .z_vld(h_z_vld), .z_rdy(h_z_rdy)
    );

    localparam int NV = 15;
    localparam logic [50:0] VEC [NV] = '{
        {16'h3F80, 16'h4000, 1'b0, 16'h4040, 1'b0, 1'b0},
        {16'h3F80, 16'h3F80, 1'b0, 16'h4000, 1'b0, 1'b0},
        {16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 1'b0, 1'b0},
        {16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 1'b0, 1'b0},
        {16'h3F80, 16'h3B81, 1'b0, 16'h3F81, 1'b0, 1'b0},
        {16'h4040, 16'h4040, 1'b1, 16'h0000, 1'b0, 1'b0},
        {16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0},
        {16'h3F80, 16'h4000, 1'b1, 16'hBF80, 1'b0, 1'b0},
        {16'h0001, 16'h3F80, 1'b0, 16'h3F80, 1'b0, 1'b0},
        {16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 1'b1, 1'b0},
        {16'h7F80, 16'hFF80, 1'b0, 16'h7FC0, 1'b0, 1'b1},
        {16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 1'b0, 1'b1},
        {16'h7F80, 16'hFF80, 1'b1, 16'h7F80, 1'b0, 1'b0},
        {16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0},
        {16'h4000, 16'hBF80, 1'b0, 16'h3F80, 1'b0, 1'b0}
    };

    localparam logic [50:0] FV [3] = '{
        {16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0},
        {16'h3C00, 16'h4000, 1'b0, 16'h4200, 1'b0, 1'b0},
        {16'h3C00, 16'h4000, 1'b1, 16'hBC00, 1'b0, 1'b0}
    };

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_vec(input int i);
        logic [50:0] v;
        v = VEC[i];
        @(negedge clk);
        a = v[50:35]; b = v[34:19]; op = v[18];
        in_vld = 1'b1; z_rdy = 1'b1;
        #1;
        chk($sformatf("v%0d in_rdy", i), 32'(in_rdy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_vld = 1'b0;
        chk($sformatf("v%0d lat1", i), 32'(z_vld), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d lat2", i), 32'(z_vld), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d vld", i), 32'(z_vld), 32'd1);
        chk($sformatf("v%0d z", i), 32'(z), 32'(v[17:2]));
        chk($sformatf("v%0d ovf", i), 32'(z_ovf), 32'(v[1]));
        chk($sformatf("v%0d inv", i), 32'(z_inv), 32'(v[0]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [50:0] v, e;
        logic [17:0] q[$];
        logic [17:0] hd;
        int idx, sent, got, cur;
        bit acc, pend;

        a = '0; b = '0; op = 1'b0; in_vld = 1'b0; z_rdy = 1'b1;
        h_a = '0; h_b = '0; h_op = 1'b0; h_in_vld = 1'b0; h_z_rdy = 1'b1;

        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst z_vld", 32'(z_vld), 32'd0);
        chk("rst z", 32'(z), 32'd0);
        chk("rst z_ovf", 32'(z_ovf), 32'd0);
        chk("rst z_inv", 32'(z_inv), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst in_rdy", 32'(in_rdy), 32'd1);

        // directed vectors, one at a time
        for (int i = 0; i < NV; i++)
            run_vec(i);

        // backpressure: 5 beats against a stalled sink
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            z_rdy = 1'b0;
            v = VEC[idx < 5 ? idx : 0];
            a = v[50:35]; b = v[34:19]; op = v[18];
            in_vld = (idx < 5);
            #1;
            acc = in_vld & in_rdy;
            @(posedge clk);
            if (acc) idx++;
        end
        @(negedge clk);
        e = VEC[0];
        chk("bp accepted", 32'(idx), 32'd3);
        chk("bp in_rdy", 32'(in_rdy), 32'd0);
        chk("bp hold vld", 32'(z_vld), 32'd1);
        chk("bp hold z", 32'(z), 32'(e[17:2]));
        for (int k = 0; k < 5; k++) begin
            z_rdy = 1'b1;
            v = VEC[idx < 5 ? idx : 0];
            a = v[50:35]; b = v[34:19]; op = v[18];
            in_vld = (idx < 5);
            #1;
            e = VEC[k];
            chk($sformatf("bp out%0d vld", k), 32'(z_vld), 32'd1);
            chk($sformatf("bp out%0d z", k), 32'(z), 32'(e[17:2]));
            acc = in_vld & in_rdy;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
        end
        in_vld = 1'b0;
        chk("bp drained", 32'(z_vld), 32'd0);

        // random in_vld / z_rdy against a scoreboard of known results
        sent = 0; got = 0; pend = 1'b0; cur = 0;
        for (int cyc = 0; cyc < 5000 && got < 300; cyc++) begin
            @(negedge clk);
            if (!pend && sent < 300 && $urandom_range(0, 3) != 0) begin
                cur  = $urandom_range(0, NV - 1);
                pend = 1'b1;
            end
            v = VEC[cur];
            a = v[50:35]; b = v[34:19]; op = v[18];
            in_vld = pend;
            z_rdy  = ($urandom_range(0, 3) != 0);
            #1;
            if (z_vld) begin
                chk("rnd queue", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    hd = q[0];
                    chk("rnd z", 32'(z), 32'(hd[17:2]));
                    chk("rnd flags", 32'({z_ovf, z_inv}), 32'(hd[1:0]));
                    if (z_rdy) begin
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            if (pend && in_rdy) begin
                q.push_back(v[17:0]);
                sent++;
                pend = 1'b0;
            end
            @(posedge clk);
        end
        chk("rnd count", 32'(got), 32'd300);
        @(negedge clk);
        in_vld = 1'b0; z_rdy = 1'b1;
        repeat (4) @(negedge clk);

        // reset with three beats in flight
        for (int k = 0; k < 3; k++) begin
            v = VEC[k];
            a = v[50:35]; b = v[34:19]; op = v[18];
            in_vld = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_vld = 1'b0;
        chk("mid full", 32'(z_vld), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid rst z_vld", 32'(z_vld), 32'd0);
        chk("mid rst z", 32'(z), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid in_rdy", 32'(in_rdy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mid stale%0d", k), 32'(z_vld), 32'd0);
        end
        run_vec(1);

        // fp16 instance
        for (int i = 0; i < 3; i++) begin
            v = FV[i];
            @(negedge clk);
            h_a = v[50:35]; h_b = v[34:19]; h_op = v[18];
            h_in_vld = 1'b1;
            #1;
            chk($sformatf("h%0d in_rdy", i), 32'(h_in_rdy), 32'd1);
            @(posedge clk);
            @(negedge clk);
            h_in_vld = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("h%0d lat2", i), 32'(h_z_vld), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("h%0d vld", i), 32'(h_z_vld), 32'd1);
            chk($sformatf("h%0d z", i), 32'(h_z), 32'(v[17:2]));
            chk($sformatf("h%0d flags", i), 32'({h_z_ovf, h_z_inv}),
                32'(v[1:0]));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
